// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Parametrised pipeline-boundary register with a valid/ready handshake and a
// 2-entry skid buffer. The skid buffer lets in_ready be decoded purely from
// state flops, so no combinational path runs from out_ready back to in_ready.
// Entries leave in strict FIFO order. The skid entry is always younger than
// the main entry.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side (in_valid & in_ready upstream, out_valid & out_ready
// downstream). valid must not depend on ready; ready is state-decoded only.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   empty the stage this cycle (inserts a bubble)
//   in_valid/in_ready       upstream handshake
//   in_ctrl, in_data        upstream control field and payload
//   out_valid/out_ready     downstream handshake
//   out_ctrl, out_data      head entry (always from the main register)
//   occupancy               entries held, 0..2 (also the FSM state encoding)
//   stall_cycles            saturating count of out_valid & !out_ready cycles
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W              = 101,
    parameter int CTRL_W              = 4,
    parameter bit CTRL_ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W               = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic in_xfer;
    logic out_xfer;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // State register and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

    // Next-state and register-load decisions.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Flush wins over everything. Only the control fields are cleared;
            // the payloads are dead once the stage is empty.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_xfer) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (out_xfer) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Stall counter saturates at all-ones; flush does not touch it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign out_data     = main_data_q;
    assign out_ctrl     = (CTRL_ZERO_ON_BUBBLE && !out_valid) ? '0 : main_ctrl_q;
    assign occupancy    = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid. The reference model is a plain queue of held
// entries: pushes follow accepted inputs, pops follow delivered outputs, a
// flush empties it, and the stall count follows the queue being non-empty
// while out_ready is low.
module tb_pipe_stage_skid;

    localparam int DATA_W = 101;
    localparam int CTRL_W = 4;
    localparam int EW     = CTRL_W + DATA_W;

    // clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cycles;

    pipe_stage_skid dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    // second instance: narrow counter, control not zeroed on bubbles
    logic       d2_flush = 1'b0;
    logic       d2_in_valid = 1'b0;
    logic       d2_in_ready;
    logic [3:0] d2_in_ctrl = '0;
    logic [7:0] d2_in_data = '0;
    logic       d2_out_valid;
    logic       d2_out_ready = 1'b1;
    logic [3:0] d2_out_ctrl;
    logic [7:0] d2_out_data;
    logic [1:0] d2_occupancy;
    logic [1:0] d2_stall_cycles;

    pipe_stage_skid #(
        .DATA_W(8), .CTRL_W(4), .CTRL_ZERO_ON_BUBBLE(1'b0), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .in_ctrl(d2_in_ctrl), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .out_ctrl(d2_out_ctrl), .out_data(d2_out_data),
        .occupancy(d2_occupancy), .stall_cycles(d2_stall_cycles)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [15:0]   stall_exp = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    // what the driver expects to happen at the next rising edge
    logic          pend_push = 1'b0;
    logic          pend_flush = 1'b0;
    logic [EW-1:0] pend_item = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the consequences of the edge that just passed to the model.
    task automatic commit_edge();
        if (pend_flush) exp_q.delete();
        else if (pend_push) exp_q.push_back(pend_item);
        pend_push  = 1'b0;
        pend_flush = 1'b0;
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic drive_cycle(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic ordy,
                               input logic fl);
        @(posedge clk);
        #1;
        commit_edge();
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        pend_flush = fl;
        pend_push  = v && (exp_q.size() < 2) && !fl;
        pend_item  = {c, d};
    endtask

    // Monitor: compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        int sz;
        logic [EW-1:0] head;
        sz = exp_q.size();
        check("occupancy", 128'(occupancy), 128'(sz));
        check("in_ready", 128'(in_ready), 128'(sz < 2));
        check("out_valid", 128'(out_valid), 128'(sz != 0));
        check("stall_cycles", 128'(stall_cycles), 128'(stall_exp));
        if (sz == 0) check("out_ctrl_bubble", 128'(out_ctrl), 128'(0));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 128'(1), 128'(0));
            end else begin
                head = exp_q.pop_front();
                check("out_ctrl", 128'(out_ctrl), 128'(head[EW-1:DATA_W]));
                check("out_data", 128'(out_data), 128'(head[DATA_W-1:0]));
            end
        end
        if (rst_n && sz != 0 && !out_ready && stall_exp != 16'hFFFF) stall_exp++;
    end

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    initial begin
        logic [DATA_W-1:0] a, b, c;
        // reset state
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // first entry after reset
        drive_cycle(1'b1, 4'hB, 101'h1, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        #1 check("first_out_data", 128'(out_data), 128'h1);
        check("first_out_ctrl", 128'(out_ctrl), 128'hB);

        // streaming at full rate
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, CTRL_W'(i + 1), rand_data(), 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h7, rand_data(), 1'b1, 1'b0);
        #1 check("stream_occupancy", 128'(occupancy), 128'(1));
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        #1 check("stream_no_stall", 128'(stall_cycles), 128'(0));

        // fill to FULL, hold, drain in order
        a = rand_data();
        b = rand_data();
        drive_cycle(1'b1, 4'h3, a, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'h5, b, 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b0, 1'b0);
        #1 check("full_occupancy", 128'(occupancy), 128'(2));
        check("full_in_ready", 128'(in_ready), 128'(0));
        check("full_head", 128'(out_data), 128'(a));
        drive_cycle(1'b0, 4'h0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        #1 check("drain_stall_count", 128'(stall_cycles), 128'(4));

        // flush while FULL with a new entry offered
        c = rand_data();
        drive_cycle(1'b1, 4'h1, rand_data(), 1'b0, 1'b0);
        drive_cycle(1'b1, 4'h2, rand_data(), 1'b0, 1'b0);
        drive_cycle(1'b1, 4'hF, c, 1'b0, 1'b1);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        #1 check("flush_occupancy", 128'(occupancy), 128'(0));
        check("flush_out_ctrl", 128'(out_ctrl), 128'(0));
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, CTRL_W'($urandom()), rand_data(),
                        $urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3),
                        $urandom_range(0, 39) == 0);
        end

        // asynchronous reset while BUSY
        drive_cycle(1'b1, 4'hA, rand_data(), 1'b0, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b0, 1'b0);
        #1 check("pre_reset_valid", 128'(out_valid), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_occupancy", 128'(occupancy), 128'(0));
        check("async_rst_ctrl", 128'(out_ctrl), 128'(0));
        check("async_rst_stall", 128'(stall_cycles), 128'(0));
        exp_q.delete();
        stall_exp  = '0;
        pend_push  = 1'b0;
        pend_flush = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // accepts normally after reset
        drive_cycle(1'b1, 4'h6, 101'h55, 1'b1, 1'b0);
        drive_cycle(1'b1, 4'h9, 101'h66, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);

        // narrow counter saturation, ctrl kept visible on bubbles
        @(posedge clk);
        #1;
        d2_in_valid = 1'b1; d2_in_ctrl = 4'h5; d2_in_data = 8'h33; d2_out_ready = 1'b0;
        @(posedge clk);
        #1 d2_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("d2_stall_saturate", 128'(d2_stall_cycles), 128'(3));
        check("d2_out_valid", 128'(d2_out_valid), 128'(1));
        check("d2_out_data", 128'(d2_out_data), 128'h33);
        d2_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("d2_drained", 128'(d2_out_valid), 128'(0));
        check("d2_ctrl_unmasked", 128'(d2_out_ctrl), 128'h5);
        check("d2_stall_hold", 128'(d2_stall_cycles), 128'(3));

        drive_cycle(1'b0, 4'h0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1 check("model_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-boundary register, successor to the fixed execute-to-memory register. It carries a generic control field and data payload between any two pipeline stages. Unlike the fixed register, it adds a valid/ready handshake, a 2-entry skid buffer so upstream never sees a combinational path from downstream ready, a flush that inserts a bubble, bubble-safe control zeroing, and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 101, payload width (default packs ALU result 32 + write data 32 + rd 5 + pc+4 32).
CTRL_W, 4, control width (default reg_write, mem_write, result_src[1:0]).
CTRL_ZERO_ON_BUBBLE, 1, when 1, out_ctrl is forced to 0 whenever out_valid=0.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  discard all held entries this cycle.
in_valid  in  1  upstream entry present.
in_ready  out  1  stage can accept; decoded from state flops only.
in_ctrl  in  CTRL_W  upstream control field.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  entry presented downstream.
out_ready  in  1  downstream accepts.
out_ctrl  out  CTRL_W  control of head entry.
out_data  out  DATA_W  payload of head entry.
occupancy  out  2  entries held (0..2).
stall_cycles  out  CNT_W  saturating count of out_valid & !out_ready cycles.

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; main and skid registers (ctrl and data) cleared to 0; stall_cycles 0. Outputs during reset: out_valid 0, out_ctrl 0, out_data 0, occupancy 0, in_ready 1. No transfer is recorded while reset is asserted. Reset mid-transfer drops all entries.
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready. A transfer completes on the rising edge where it is true.
- in_ready = (state != FULL). out_valid = (state != EMPTY). out_data and out_ctrl always come from the main register (registered outputs, no combinational path from the inputs).
- States:
  - EMPTY (occupancy 0): in_xfer -> main <= in, go to BUSY.
  - BUSY (occupancy 1):
    - in_xfer & out_xfer -> main <= in, stay BUSY.
    - in_xfer only -> skid <= in, go to FULL.
    - out_xfer only -> go to EMPTY.
    - neither -> hold.
  - FULL (occupancy 2): in_ready 0. out_xfer -> main <= skid, go to BUSY. Otherwise hold.
- Latency: 1 cycle from in_xfer into EMPTY to out_valid. Throughput is 1 entry/cycle while out_ready stays high.
- Ordering: strict FIFO; skid content always younger than main.
- Flush has highest priority: next state EMPTY regardless of in_valid or out_ready.
  - An in_xfer in the flush cycle is discarded.
  - An out_xfer in the flush cycle is still complete from the downstream view.
  - main and skid ctrl are cleared to 0; data is left unchanged.
- CTRL_ZERO_ON_BUBBLE=1: out_ctrl = 0 whenever out_valid=0, so no stale reg_write/mem_write is ever presented. When 0, out_ctrl shows the main register unconditionally.
- stall_cycles increments by 1 each cycle with out_valid & !out_ready. It saturates at all-ones with no wrap. It is unaffected by flush and cleared only by reset.
- Holding: registers load only on the transitions listed above; no other cycle alters the contents.

Test Plan:
- Reset release, in_valid=1, in_data=0x1, in_ctrl=0xB, out_ready=1 -> next cycle out_valid=1, out_data=0x1, out_ctrl=0xB, occupancy 1, in_ready 1.
- Streaming A,B,C on consecutive cycles with out_ready=1 -> outputs A,B,C on consecutive cycles, occupancy stays 1, stall_cycles 0.
- Load A, then B with out_ready=0 -> occupancy 2, in_ready 0, out_data=A. Hold 3 cycles, then raise out_ready -> A, then B delivered in order; stall_cycles=4.
- FULL state plus flush=1 with in_valid=1 carrying C -> next cycle occupancy 0, out_valid 0, out_ctrl 0, C never appears at the output.
- CNT_W=2, out_valid with out_ready=0 for 6 cycles -> stall_cycles reaches 3 and stays 3.
- rst_n asserted asynchronously mid-cycle while BUSY -> out_valid, occupancy and out_ctrl go 0 immediately without a clock edge. After release, the stage accepts new input normally.
